// File: rtl/acpo_pkg.sv
// Shared types and helpers for the activation/pool/write-back stage.
package acpo_pkg;

    typedef enum logic [1:0] {
        ACT_BYPASS     = 2'd0,
        ACT_RELU       = 2'd1,
        ACT_RELU_SHIFT = 2'd2
    } act_mode_e;

    typedef enum logic [1:0] {
        WIN1     = 2'd0,
        WIN2     = 2'd1,
        WIN4     = 2'd2,
        WIN_RSVD = 2'd3
    } pool_win_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_SWAP
    } state_e;

    function automatic logic [2:0] win_len(input pool_win_e w);
        logic [2:0] n;
        case (w)
            WIN2:    n = 3'd2;
            WIN4:    n = 3'd4;
            default: n = 3'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/acpo_lane.sv
// One accumulator lane: activation, running max-pool and bank write counter.
// Latency: accept -> activation reg -> pool emit reg -> bank write (3 edges).
// Backpressure: none locally; the top gates in_vld with its single ready.
module acpo_lane
    import acpo_pkg::*;
#(
    parameter int ACC_W  = 16,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    localparam int SHIFT_W = $clog2(ACC_W),
    localparam int IDX_W   = $clog2(DEPTH),
    localparam int CNT_W   = IDX_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               in_vld,
    input  logic               in_last,
    input  logic [ACC_W-1:0]   in_dat,
    input  logic [ADDR_W-1:0]  in_tag,
    input  act_mode_e          act_mode,
    input  logic [SHIFT_W-1:0] act_shift,
    input  logic [2:0]         win,
    output logic               wr_vld,
    output logic [IDX_W-1:0]   wr_idx,
    output logic [DATA_W-1:0]  wr_dat,
    output logic [ADDR_W-1:0]  wr_tag,
    output logic [CNT_W-1:0]   cnt,
    output logic               busy,
    output logic               ovf
);

    logic [DATA_W-1:0] act_val;
    logic              s1_vld;
    logic              s1_last;
    logic [DATA_W-1:0] s1_dat;
    logic [ADDR_W-1:0] s1_tag;
    logic [2:0]        pcnt;
    logic [DATA_W-1:0] pmax;
    logic [ADDR_W-1:0] ptag;
    logic [DATA_W-1:0] pool_max;
    logic [ADDR_W-1:0] pool_tag;
    logic              pool_end;
    logic              em_vld;
    logic [DATA_W-1:0] em_dat;
    logic [ADDR_W-1:0] em_tag;
    logic              full;

    function automatic logic [DATA_W-1:0] relu_sat(input logic signed [ACC_W-1:0] x);
        logic [DATA_W-1:0] y;
        if (x[ACC_W-1])
            y = '0;
        else if (|x[ACC_W-2:DATA_W])
            y = '1;
        else
            y = x[DATA_W-1:0];
        return y;
    endfunction

    always_comb begin
        act_val = in_dat[DATA_W-1:0];
        case (act_mode)
            ACT_RELU:       act_val = relu_sat(in_dat);
            ACT_RELU_SHIFT: act_val = relu_sat($signed(in_dat) >>> act_shift);
            default:        ;
        endcase
    end

    // First sample of a window seeds both the max and the tag.
    always_comb begin
        pool_max = (pcnt == 3'd0 || s1_dat > pmax) ? s1_dat : pmax;
        pool_tag = (pcnt == 3'd0) ? s1_tag : ptag;
        pool_end = s1_last || ((pcnt + 3'd1) >= win);
    end

    assign full   = (cnt == CNT_W'(DEPTH));
    assign wr_vld = em_vld && !full;
    assign wr_idx = cnt[IDX_W-1:0];
    assign wr_dat = em_dat;
    assign wr_tag = em_tag;
    assign busy   = s1_vld || em_vld;
    assign ovf    = em_vld && full;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_dat  <= '0;
            s1_tag  <= '0;
            pcnt    <= 3'd0;
            pmax    <= '0;
            ptag    <= '0;
            em_vld  <= 1'b0;
            em_dat  <= '0;
            em_tag  <= '0;
            cnt     <= '0;
        end else begin
            s1_vld <= in_vld;
            if (in_vld) begin
                s1_last <= in_last;
                s1_dat  <= act_val;
                s1_tag  <= in_tag;
            end
            em_vld <= s1_vld && pool_end;
            if (s1_vld) begin
                if (pool_end) begin
                    pcnt   <= 3'd0;
                    em_dat <= pool_max;
                    em_tag <= pool_tag;
                end else begin
                    pcnt <= pcnt + 3'd1;
                    pmax <= pool_max;
                    ptag <= pool_tag;
                end
            end
            if (em_vld && !full)
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/acpo_pingpong_unit.sv
// Activation/pool stage feeding a two-bank ping-pong result buffer.
// Latency: sample accept to bank write 3 edges; reads return 1 cycle after rd_en_i.
// Backpressure: acc_ready_o drops only while a finished frame waits for a free bank.
module acpo_pingpong_unit
    import acpo_pkg::*;
#(
    parameter int N_CH   = 16,
    parameter int ACC_W  = 16,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    localparam int SHIFT_W = $clog2(ACC_W),
    localparam int LANE_W  = $clog2(N_CH),
    localparam int IDX_W   = $clog2(DEPTH),
    localparam int CNT_W   = IDX_W + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_load_i,
    input  logic [1:0]                     cfg_act_i,
    input  logic [SHIFT_W-1:0]             cfg_shift_i,
    input  logic [1:0]                     cfg_pool_i,
    input  logic [N_CH-1:0]                acc_valid_i,
    input  logic [N_CH-1:0]                acc_last_i,
    input  logic [N_CH-1:0][ACC_W-1:0]     acc_data_i,
    input  logic [N_CH-1:0][ADDR_W-1:0]    acc_addr_i,
    output logic                           acc_ready_o,
    input  logic                           rd_en_i,
    input  logic [LANE_W+IDX_W-1:0]        rd_addr_i,
    output logic [DATA_W-1:0]              rd_data_o,
    output logic [ADDR_W-1:0]              rd_tag_o,
    output logic [N_CH-1:0][CNT_W-1:0]     rd_count_o,
    output logic                           bank_ready_o,
    input  logic                           rd_release_i,
    output logic                           frame_done_o,
    output logic                           overflow_o
);

    state_e                      state;
    state_e                      state_nxt;
    logic                        do_swap;
    logic                        wr_bank;
    act_mode_e                   cfg_act;
    logic [SHIFT_W-1:0]          cfg_shift;
    pool_win_e                   cfg_pool;
    logic [N_CH-1:0]             accept;
    logic [N_CH-1:0]             lane_done;
    logic [N_CH-1:0]             lane_busy;
    logic [N_CH-1:0]             lane_ovf;
    logic [N_CH-1:0]             lane_wr_vld;
    logic [N_CH-1:0][IDX_W-1:0]  lane_wr_idx;
    logic [N_CH-1:0][DATA_W-1:0] lane_wr_dat;
    logic [N_CH-1:0][ADDR_W-1:0] lane_wr_tag;
    logic [N_CH-1:0][CNT_W-1:0]  lane_cnt;
    logic [N_CH-1:0][CNT_W-1:0]  rd_cnt;
    logic [DATA_W-1:0]           lane_rd_dat [N_CH];
    logic [ADDR_W-1:0]           lane_rd_tag [N_CH];
    logic [LANE_W-1:0]           rd_lane;
    logic [IDX_W-1:0]            rd_entry;
    logic [LANE_W-1:0]           rd_lane_q;
    logic                        rd_zero;

    assign acc_ready_o = (state != ST_SWAP);
    assign accept      = acc_valid_i & {N_CH{acc_ready_o}};
    assign rd_lane     = rd_addr_i[IDX_W +: LANE_W];
    assign rd_entry    = rd_addr_i[IDX_W-1:0];
    assign rd_count_o  = bank_ready_o ? rd_cnt : '0;
    assign rd_data_o   = rd_zero ? '0 : lane_rd_dat[rd_lane_q];
    assign rd_tag_o    = rd_zero ? '0 : lane_rd_tag[rd_lane_q];

    always_comb begin
        state_nxt = state;
        do_swap   = 1'b0;
        case (state)
            ST_IDLE: if (|accept) state_nxt = ST_RUN;
            // Lane pipelines must drain before the bank can be handed over.
            ST_RUN:  if (&lane_done && !(|lane_busy)) state_nxt = ST_SWAP;
            ST_SWAP: begin
                if (!bank_ready_o || rd_release_i) begin
                    do_swap   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            wr_bank      <= 1'b0;
            bank_ready_o <= 1'b0;
            frame_done_o <= 1'b0;
            overflow_o   <= 1'b0;
            lane_done    <= '0;
            rd_cnt       <= '0;
            cfg_act      <= ACT_RELU;
            cfg_shift    <= '0;
            cfg_pool     <= WIN1;
            rd_zero      <= 1'b1;
            rd_lane_q    <= '0;
        end else begin
            state        <= state_nxt;
            frame_done_o <= do_swap;
            if (do_swap) begin
                wr_bank      <= ~wr_bank;
                bank_ready_o <= 1'b1;
                lane_done    <= '0;
                rd_cnt       <= lane_cnt;
            end else begin
                lane_done <= lane_done | (accept & acc_last_i);
                if (rd_release_i)
                    bank_ready_o <= 1'b0;
            end
            if (|lane_ovf)
                overflow_o <= 1'b1;
            if (cfg_load_i && state == ST_IDLE) begin
                cfg_act   <= act_mode_e'(cfg_act_i);
                cfg_shift <= cfg_shift_i;
                cfg_pool  <= pool_win_e'(cfg_pool_i);
            end
            if (rd_en_i) begin
                rd_zero   <= !bank_ready_o;
                rd_lane_q <= rd_lane;
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        logic [DATA_W-1:0] dmem [2*DEPTH];
        logic [ADDR_W-1:0] tmem [2*DEPTH];

        acpo_lane #(
            .ACC_W  (ACC_W),
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .clr       (do_swap),
            .in_vld    (accept[k]),
            .in_last   (acc_last_i[k]),
            .in_dat    (acc_data_i[k]),
            .in_tag    (acc_addr_i[k]),
            .act_mode  (cfg_act),
            .act_shift (cfg_shift),
            .win       (win_len(cfg_pool)),
            .wr_vld    (lane_wr_vld[k]),
            .wr_idx    (lane_wr_idx[k]),
            .wr_dat    (lane_wr_dat[k]),
            .wr_tag    (lane_wr_tag[k]),
            .cnt       (lane_cnt[k]),
            .busy      (lane_busy[k]),
            .ovf       (lane_ovf[k])
        );

        // Writes fill wr_bank; reads always come from the opposite (ready) bank.
        always_ff @(posedge clk) begin
            if (lane_wr_vld[k]) begin
                dmem[{wr_bank, lane_wr_idx[k]}] <= lane_wr_dat[k];
                tmem[{wr_bank, lane_wr_idx[k]}] <= lane_wr_tag[k];
            end
            if (rd_en_i) begin
                lane_rd_dat[k] <= dmem[{~wr_bank, rd_entry}];
                lane_rd_tag[k] <= tmem[{~wr_bank, rd_entry}];
            end
        end
    end

endmodule
